// File: rtl/ternary_result_drain.sv
// ---------------------------------------------------------------------------
// ternary_result_drain
//
// Output staging stage behind the ternary matrix-vector multiplier. Signed
// accumulator results arrive one row at a time, in any order, and are parked
// in a local buffer. Once every row of the frame is present the frame is
// streamed out one byte per handshake on an 8-bit valid/ready port, either as
// saturated int8 (one byte per row) or as sign-extended int16 (two bytes per
// row, low byte first).
//
// Ports:
//   clk        clock
//   rst_n      synchronous active-low reset
//   start      pulse: open a new frame (clears row mask and overrun)
//   in_valid   in_row/in_data carry a result this cycle
//   in_row     destination row of in_data
//   in_data    signed accumulator result
//   sat_mode   1: int8 saturated output, 0: int16 two-byte output
//   out_data   current output byte (registered)
//   out_valid  out_data is valid (registered)
//   out_ready  consumer accepts the byte when out_valid && out_ready
//   out_last   marks the final byte of the frame (registered)
//   busy       high while collecting or draining (registered)
//   overrun    sticky error: duplicate row write or write outside COLLECT
// ---------------------------------------------------------------------------
module ternary_result_drain #(
    parameter int OUT_LEN   = 8,
    parameter int ACC_WIDTH = 12,
    parameter int ROW_W     = $clog2(OUT_LEN)
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        start,
    input  logic                        in_valid,
    input  logic [ROW_W-1:0]            in_row,
    input  logic signed [ACC_WIDTH-1:0] in_data,
    input  logic                        sat_mode,
    output logic [7:0]                  out_data,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic                        out_last,
    output logic                        busy,
    output logic                        overrun
);

    localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(OUT_LEN - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        DRAIN   = 2'd2
    } state_t;

    state_t                      state_r;
    logic signed [ACC_WIDTH-1:0] buf_r [OUT_LEN];
    logic [OUT_LEN-1:0]          mask_r;
    logic [ROW_W-1:0]            rd_row_r;
    logic                        byte_sel_r;
    logic                        sat_r;
    logic                        overrun_r;
    logic [7:0]                  out_data_r;
    logic                        out_valid_r;
    logic                        out_last_r;
    logic                        busy_r;

    logic                        write_en_s;
    logic [ROW_W-1:0]            nxt_row_s;
    logic                        nxt_sel_s;
    logic [7:0]                  nxt_byte_s;
    logic                        nxt_last_s;
    logic signed [ACC_WIDTH-1:0] first_val_s;
    logic [7:0]                  first_byte_s;

    // Format one output byte from a buffered result: clamp to int8, or pick
    // the low/high byte of the 16-bit sign extension.
    function automatic logic [7:0] fmt_byte(
        input logic signed [ACC_WIDTH-1:0] v,
        input logic                        sat,
        input logic                        sel
    );
        logic signed [15:0] ext;
        logic [7:0]         res;
        ext = 16'(v);
        if (sat) begin
            if (ext > 16'sd127) begin
                res = 8'h7F;
            end else if (ext < -16'sd128) begin
                res = 8'h80;
            end else begin
                res = ext[7:0];
            end
        end else begin
            if (sel) begin
                res = ext[15:8];
            end else begin
                res = ext[7:0];
            end
        end
        return res;
    endfunction

    // Write qualification, drain pointer advance and the byte to present next.
    always_comb begin
        write_en_s   = 1'b0;
        nxt_row_s    = rd_row_r;
        nxt_sel_s    = 1'b0;
        first_val_s  = buf_r[0];
        if ((state_r == COLLECT) && !start && in_valid) begin
            write_en_s = 1'b1;
        end else begin
            write_en_s = 1'b0;
        end
        // int16 stays on the row for the high byte; int8 moves every byte.
        if (!sat_r && !byte_sel_r) begin
            nxt_row_s = rd_row_r;
            nxt_sel_s = 1'b1;
        end else begin
            nxt_row_s = rd_row_r + ROW_W'(1);
            nxt_sel_s = 1'b0;
        end
        nxt_byte_s = fmt_byte(buf_r[nxt_row_s], sat_r, nxt_sel_s);
        nxt_last_s = (nxt_row_s == LAST_ROW) && (sat_r || nxt_sel_s);
        // A row-0 write landing on the transition edge must reach the first byte.
        if (write_en_s && (in_row == ROW_W'(0))) begin
            first_val_s = in_data;
        end else begin
            first_val_s = buf_r[0];
        end
        first_byte_s = fmt_byte(first_val_s, sat_mode, 1'b0);
    end

    // Result buffer; contents need no reset because the mask gates their use.
    always_ff @(posedge clk) begin
        if (write_en_s) begin
            buf_r[in_row] <= in_data;
        end
    end

    // Frame control FSM with registered stream outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r     <= IDLE;
            mask_r      <= '0;
            rd_row_r    <= '0;
            byte_sel_r  <= 1'b0;
            sat_r       <= 1'b0;
            overrun_r   <= 1'b0;
            out_data_r  <= 8'h00;
            out_valid_r <= 1'b0;
            out_last_r  <= 1'b0;
            busy_r      <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (start) begin
                        state_r   <= COLLECT;
                        busy_r    <= 1'b1;
                        mask_r    <= '0;
                        overrun_r <= 1'b0;
                    end else if (in_valid) begin
                        overrun_r <= 1'b1;
                    end
                end
                COLLECT: begin
                    if (start) begin
                        mask_r    <= '0;
                        overrun_r <= 1'b0;
                    end else begin
                        if (in_valid) begin
                            mask_r[in_row] <= 1'b1;
                            if (mask_r[in_row]) begin
                                overrun_r <= 1'b1;
                            end
                        end
                        if (&mask_r) begin
                            state_r     <= DRAIN;
                            sat_r       <= sat_mode;
                            rd_row_r    <= '0;
                            byte_sel_r  <= 1'b0;
                            out_valid_r <= 1'b1;
                            out_last_r  <= 1'b0;
                            out_data_r  <= first_byte_s;
                        end
                    end
                end
                DRAIN: begin
                    if (in_valid) begin
                        overrun_r <= 1'b1;
                    end
                    if (out_ready) begin
                        if (out_last_r) begin
                            state_r     <= IDLE;
                            busy_r      <= 1'b0;
                            out_valid_r <= 1'b0;
                            out_last_r  <= 1'b0;
                            out_data_r  <= 8'h00;
                        end else begin
                            rd_row_r   <= nxt_row_s;
                            byte_sel_r <= nxt_sel_s;
                            out_data_r <= nxt_byte_s;
                            out_last_r <= nxt_last_s;
                        end
                    end
                end
                default: begin
                    state_r     <= IDLE;
                    busy_r      <= 1'b0;
                    out_valid_r <= 1'b0;
                    out_last_r  <= 1'b0;
                end
            endcase
        end
    end

    assign out_data  = out_data_r;
    assign out_valid = out_valid_r;
    assign out_last  = out_last_r;
    assign busy      = busy_r;
    assign overrun   = overrun_r;

endmodule

// File: tb/tb_ternary_result_drain.sv
module tb_ternary_result_drain;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic        in_valid;
    logic [2:0]  in_row;
    logic [11:0] in_data;
    logic        sat_mode;
    logic [7:0]  out_data;
    logic        out_valid;
    logic        out_ready;
    logic        out_last;
    logic        busy;
    logic        overrun;

    int tests = 0;
    int fails = 0;
    logic [7:0] exp_q[$];

    ternary_result_drain #(.OUT_LEN(8), .ACC_WIDTH(12)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid),
        .in_row(in_row), .in_data(in_data), .sat_mode(sat_mode),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .out_last(out_last), .busy(busy), .overrun(overrun)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic do_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wr(input int r, input int d);
        in_valid = 1'b1;
        in_row   = r[2:0];
        in_data  = d[11:0];
        tick();
        in_valid = 1'b0;
    endtask

    // Drain the whole frame against exp_q; toggle selects a 1,0,1,0 ready pattern.
    task automatic drain(input string tag, input bit toggle);
        int idx = 0;
        int cyc = 0;
        logic [7:0] held;
        while (idx < exp_q.size() && cyc < 200) begin
            out_ready = toggle ? ((cyc % 2) == 0) : 1'b1;
            check({tag, "_valid"}, out_valid, 1'b1);
            if (out_ready) begin
                check($sformatf("%s_byte%0d", tag, idx), out_data, exp_q[idx]);
                check($sformatf("%s_last%0d", tag, idx), out_last, (idx == exp_q.size() - 1));
                idx++;
                tick();
            end else begin
                held = out_data;
                tick();
                check($sformatf("%s_stable%0d", tag, idx), out_data, held);
            end
            cyc++;
        end
        out_ready = 1'b1;
        check({tag, "_count"}, idx, exp_q.size());
        check({tag, "_end_valid"}, out_valid, 1'b0);
        check({tag, "_end_busy"}, busy, 1'b0);
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; in_valid = 1'b0; in_row = 3'd0;
        in_data = 12'd0; sat_mode = 1'b1; out_ready = 1'b1;
        tick(); tick();
        check("rst_valid", out_valid, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_overrun", overrun, 1'b0);
        check("rst_last", out_last, 1'b0);
        check("rst_data", out_data, 8'h00);
        rst_n = 1'b1;
        tick();

        // In-order int8
        do_start();
        check("t1_busy", busy, 1'b1);
        wr(0, 5); wr(1, -3); wr(2, 127); wr(3, -128);
        wr(4, 0); wr(5, 1); wr(6, -1); wr(7, 100);
        check("t1_valid_early", out_valid, 1'b0);
        tick();
        check("t1_valid_on_time", out_valid, 1'b1);
        exp_q = '{8'h05, 8'hFD, 8'h7F, 8'h80, 8'h00, 8'h01, 8'hFF, 8'h64};
        drain("t1", 1'b0);

        // Saturation, out of order
        do_start();
        for (int r = 7; r >= 0; r--) begin
            wr(r, (r == 2) ? 300 : ((r == 5) ? -1000 : 0));
        end
        tick();
        exp_q = '{8'h00, 8'h00, 8'h7F, 8'h00, 8'h00, 8'h80, 8'h00, 8'h00};
        drain("t2", 1'b0);
        check("t2_overrun", overrun, 1'b0);

        // int16 with backpressure; sat_mode changed mid-frame must not matter
        sat_mode = 1'b0;
        do_start();
        wr(0, -2); wr(1, 'h123);
        for (int r = 2; r < 8; r++) wr(r, 0);
        tick();
        sat_mode = 1'b1;
        exp_q = '{8'hFE, 8'hFF, 8'h23, 8'h01, 8'h00, 8'h00, 8'h00, 8'h00,
                  8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        drain("t3", 1'b1);

        // Overrun: duplicate row write, then a write during DRAIN
        do_start();
        wr(3, 10);
        check("t4_no_overrun", overrun, 1'b0);
        wr(3, 20);
        check("t4_dup_overrun", overrun, 1'b1);
        wr(0, 0); wr(1, 1); wr(2, 2); wr(4, 4); wr(5, 5); wr(6, 6); wr(7, 7);
        tick();
        out_ready = 1'b0;
        in_valid = 1'b1; in_row = 3'd0; in_data = 12'd77;
        tick();
        in_valid = 1'b0;
        check("t4_drain_hold", out_data, 8'h00);
        check("t4_drain_overrun", overrun, 1'b1);
        exp_q = '{8'h00, 8'h01, 8'h02, 8'h14, 8'h04, 8'h05, 8'h06, 8'h07};
        drain("t4", 1'b0);
        check("t4_overrun_sticky", overrun, 1'b1);
        do_start();
        check("t4_start_clears", overrun, 1'b0);

        // Restart mid-COLLECT needs all rows again
        wr(0, 9); wr(1, 9); wr(2, 9); wr(3, 9);
        do_start();
        wr(4, 'h28); wr(5, 'h29); wr(6, 'h2A); wr(7, 'h2B);
        tick(); tick();
        check("t5_no_drain", out_valid, 1'b0);
        check("t5_busy", busy, 1'b1);
        wr(0, 1); wr(1, 2); wr(2, 3); wr(3, 4);
        tick();
        exp_q = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h28, 8'h29, 8'h2A, 8'h2B};
        drain("t5", 1'b0);

        // Idle write sets overrun; write alongside start is dropped silently
        wr(2, 3);
        check("t5_idle_overrun", overrun, 1'b1);
        start = 1'b1; in_valid = 1'b1; in_row = 3'd7; in_data = 12'h055;
        tick();
        start = 1'b0; in_valid = 1'b0;
        check("t5_start_write_overrun", overrun, 1'b0);
        for (int r = 0; r < 7; r++) wr(r, 'h10 + r);
        tick(); tick();
        check("t5_row7_needed", out_valid, 1'b0);
        wr(7, 'h17);
        tick();

        // Reset mid-DRAIN after three bytes
        in_valid = 1'b1; in_row = 3'd1; in_data = 12'h0AA;
        for (int i = 0; i < 3; i++) begin
            check($sformatf("t6_byte%0d", i), out_data, 8'h10 + 8'(i));
            tick();
        end
        in_valid = 1'b0;
        check("t6_overrun_set", overrun, 1'b1);
        rst_n = 1'b0;
        tick();
        check("t6_rst_valid", out_valid, 1'b0);
        check("t6_rst_busy", busy, 1'b0);
        check("t6_rst_overrun", overrun, 1'b0);
        rst_n = 1'b1;
        do_start();
        for (int r = 0; r < 8; r++) wr(r, 'h30 + r);
        tick();
        exp_q = '{8'h30, 8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37};
        drain("t6", 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
